// File: rtl/banco_registradores_sb.sv
// Register file with optional zero register, write bypass
// and a per-register pending-write scoreboard.
module banco_registradores_sb #(
  parameter int LARGURA  = 32,
  parameter int N_REGS   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(N_REGS)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [AW-1:0]      Fonte1,
  input  logic [AW-1:0]      Fonte2,
  output logic [LARGURA-1:0] Dado1,
  output logic [LARGURA-1:0] Dado2,
  output logic               Pendente1,
  output logic               Pendente2,
  input  logic               Esc,
  input  logic [AW-1:0]      RegEsc,
  input  logic [LARGURA-1:0] Dado,
  input  logic               Reserva,
  input  logic [AW-1:0]      RegReserva,
  output logic [AW:0]        NumPend
);

  logic [LARGURA-1:0] regs_q [N_REGS];
  logic [N_REGS-1:0]  pend_q;
  logic [N_REGS-1:0]  pend_d;
  logic [AW:0]        num_q;
  logic [AW:0]        num_d;
  logic               wr_en;
  logic               res_en;

  // Register 0 swallows writes and reservations when hardwired
  assign wr_en  = Esc &&
                  !((ZERO_REG != 0) && (RegEsc == '0));
  assign res_en = Reserva &&
                  !((ZERO_REG != 0) && (RegReserva == '0));

  // Storage array update
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[RegEsc] <= Dado;
    end
  end

  // Scoreboard next state: completion clears, a new
  // reservation applied last so the new producer wins
  always_comb begin
    pend_d = pend_q;
    if (Esc) begin
      pend_d[RegEsc] = 1'b0;
    end
    if (res_en) begin
      pend_d[RegReserva] = 1'b1;
    end
    num_d = '0;
    for (int i = 0; i < N_REGS; i++) begin
      num_d = num_d + {{AW{1'b0}}, pend_d[i]};
    end
  end

  // Scoreboard and pending-count registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pend_q <= '0;
      num_q  <= '0;
    end else begin
      pend_q <= pend_d;
      num_q  <= num_d;
    end
  end

  assign NumPend = num_q;

  // Read port 1: storage, then bypass, then zero/reset
  always_comb begin
    Dado1     = regs_q[Fonte1];
    Pendente1 = pend_q[Fonte1];
    if ((BYPASS != 0) && Esc && (RegEsc == Fonte1)) begin
      Dado1 = Dado;
    end
    if ((ZERO_REG != 0) && (Fonte1 == '0)) begin
      Dado1 = '0;
    end
    if (Rst) begin
      Dado1     = '0;
      Pendente1 = 1'b0;
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    Dado2     = regs_q[Fonte2];
    Pendente2 = pend_q[Fonte2];
    if ((BYPASS != 0) && Esc && (RegEsc == Fonte2)) begin
      Dado2 = Dado;
    end
    if ((ZERO_REG != 0) && (Fonte2 == '0)) begin
      Dado2 = '0;
    end
    if (Rst) begin
      Dado2     = '0;
      Pendente2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_banco_registradores_sb.sv
// Bench: default 4x32 instance driven from a vector table,
// 16x64 zero-reg/no-bypass instance against a reference model.
module tb_banco_registradores_sb;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instance A: LARGURA=32 N_REGS=4 ZERO_REG=0 BYPASS=1
  logic        aRst, aEsc, aRes, aP1, aP2;
  logic [1:0]  aRe, aRr, aF1, aF2;
  logic [31:0] aD, aD1, aD2;
  logic [2:0]  aNp;

  banco_registradores_sb #(
    .LARGURA(32), .N_REGS(4), .ZERO_REG(0), .BYPASS(1)
  ) dut_a (
    .Clk(Clk), .Rst(aRst), .Fonte1(aF1), .Fonte2(aF2),
    .Dado1(aD1), .Dado2(aD2),
    .Pendente1(aP1), .Pendente2(aP2),
    .Esc(aEsc), .RegEsc(aRe), .Dado(aD),
    .Reserva(aRes), .RegReserva(aRr), .NumPend(aNp)
  );

  // Instance B: LARGURA=64 N_REGS=16 ZERO_REG=1 BYPASS=0
  logic        bRst, bEsc, bRes, bP1, bP2;
  logic [3:0]  bRe, bRr, bF1, bF2;
  logic [63:0] bD, bD1, bD2;
  logic [4:0]  bNp;

  banco_registradores_sb #(
    .LARGURA(64), .N_REGS(16), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .Clk(Clk), .Rst(bRst), .Fonte1(bF1), .Fonte2(bF2),
    .Dado1(bD1), .Dado2(bD2),
    .Pendente1(bP1), .Pendente2(bP2),
    .Esc(bEsc), .RegEsc(bRe), .Dado(bD),
    .Reserva(bRes), .RegReserva(bRr), .NumPend(bNp)
  );

  typedef struct {
    logic        rst, esc;
    logic [1:0]  re;
    logic [31:0] d;
    logic        res;
    logic [1:0]  rr, f1, f2;
    logic [31:0] e1, e2;
    logic        p1, p2;
    logic [2:0]  np;
  } vec_t;

  typedef struct {
    logic [63:0] d1, d2;
    logic        p1, p2;
    logic [4:0]  np;
  } exp_t;

  vec_t tv[$];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_fail = 0;

  logic [63:0] m_reg [16];
  logic [15:0] m_pend;

  function automatic vec_t mk(
    input logic rst, esc, input logic [1:0] re,
    input logic [31:0] d, input logic res,
    input logic [1:0] rr, f1, f2,
    input logic [31:0] e1, e2,
    input logic p1, p2, input logic [2:0] np);
    vec_t v;
    v.rst = rst; v.esc = esc; v.re = re; v.d = d;
    v.res = res; v.rr = rr; v.f1 = f1; v.f2 = f2;
    v.e1 = e1; v.e2 = e2; v.p1 = p1; v.p2 = p2;
    v.np = np;
    return v;
  endfunction

  task automatic check(input string nm, input exp_t g);
    exp_t e;
    n_vec++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sbq.pop_front();
    if (g.d1 !== e.d1 || g.d2 !== e.d2 || g.p1 !== e.p1 ||
        g.p2 !== e.p2 || g.np !== e.np) begin
      n_fail++;
      $display({"FAIL %s: got d1=%h d2=%h p=%b%b np=%0d",
                " want d1=%h d2=%h p=%b%b np=%0d"},
               nm, g.d1, g.d2, g.p1, g.p2, g.np,
               e.d1, e.d2, e.p1, e.p2, e.np);
    end
  endtask

  task automatic step_a(input int idx);
    vec_t v;
    exp_t e, g;
    v = tv[idx];
    @(posedge Clk);
    #1;
    aRst = v.rst; aEsc = v.esc; aRe = v.re; aD = v.d;
    aRes = v.res; aRr = v.rr; aF1 = v.f1; aF2 = v.f2;
    e.d1 = {32'h0, v.e1}; e.d2 = {32'h0, v.e2};
    e.p1 = v.p1; e.p2 = v.p2; e.np = {2'b0, v.np};
    sbq.push_back(e);
    @(negedge Clk);
    g.d1 = {32'h0, aD1}; g.d2 = {32'h0, aD2};
    g.p1 = aP1; g.p2 = aP2; g.np = {2'b0, aNp};
    check($sformatf("tableA[%0d]", idx), g);
  endtask

  function automatic logic [4:0] m_count();
    logic [4:0] c = '0;
    for (int i = 0; i < 16; i++) c += {4'b0, m_pend[i]};
    return c;
  endfunction

  task automatic step_b(
    input string nm, input logic rst, esc,
    input logic [3:0] re, input logic [63:0] d,
    input logic res, input logic [3:0] rr, f1, f2);
    exp_t e, g;
    @(posedge Clk);
    #1;
    bRst = rst; bEsc = esc; bRe = re; bD = d;
    bRes = res; bRr = rr; bF1 = f1; bF2 = f2;
    e.d1 = (rst || f1 == 0) ? 64'h0 : m_reg[f1];
    e.d2 = (rst || f2 == 0) ? 64'h0 : m_reg[f2];
    e.p1 = rst ? 1'b0 : m_pend[f1];
    e.p2 = rst ? 1'b0 : m_pend[f2];
    e.np = m_count();
    sbq.push_back(e);
    @(negedge Clk);
    g.d1 = bD1; g.d2 = bD2; g.p1 = bP1; g.p2 = bP2;
    g.np = bNp;
    check(nm, g);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_pend = '0;
    end else begin
      if (esc && re != 0) m_reg[re] = d;
      if (esc) m_pend[re] = 1'b0;
      if (res && rr != 0) m_pend[rr] = 1'b1;
    end
  endtask

  initial begin
    aRst = 1; aEsc = 0; aRe = 0; aD = 0;
    aRes = 0; aRr = 0; aF1 = 0; aF2 = 0;
    bRst = 1; bEsc = 0; bRe = 0; bD = 0;
    bRes = 0; bRr = 0; bF1 = 0; bF2 = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pend = '0;
    @(posedge Clk);
    #1;
    aRst = 0; bRst = 0;

    // rst esc re d res rr f1 f2 | e1 e2 p1 p2 np
    tv.push_back(mk(1,1,2,32'hAAAA5555,0,0,2,2, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,2,0, 0,0,0,0,0));
    tv.push_back(mk(0,1,2,32'h048FC24A,0,0,2,1,
                    32'h048FC24A,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,2,2,
                    32'h048FC24A,32'h048FC24A,0,0,0));
    tv.push_back(mk(0,0,0,0,1,1,1,2, 0,32'h048FC24A,0,0,0));
    tv.push_back(mk(0,1,1,32'h11111111,1,1,1,1,
                    32'h11111111,32'h11111111,1,1,1));
    tv.push_back(mk(0,1,1,32'h22222222,0,0,1,3,
                    32'h22222222,0,1,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1,2,
                    32'h22222222,32'h048FC24A,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,1, 0,32'h22222222,0,0,0));
    tv.push_back(mk(0,0,0,0,1,1,0,1, 0,32'h22222222,1,0,1));
    tv.push_back(mk(0,0,0,0,1,2,1,2,
                    32'h22222222,32'h048FC24A,1,0,2));
    tv.push_back(mk(0,0,0,0,1,3,2,3, 32'h048FC24A,0,1,0,3));
    tv.push_back(mk(0,0,0,0,1,0,3,0, 0,0,1,1,4));
    tv.push_back(mk(0,0,0,0,0,0,0,3, 0,0,1,1,4));
    tv.push_back(mk(0,1,3,32'h3,1,0,3,3, 3,3,1,1,4));
    tv.push_back(mk(0,1,0,32'h5,1,2,0,3, 5,3,1,0,3));
    tv.push_back(mk(0,0,0,0,0,0,0,2, 5,32'h048FC24A,0,1,2));
    tv.push_back(mk(1,0,0,0,0,0,2,0, 0,0,0,0,2));
    tv.push_back(mk(0,0,0,0,0,0,2,1, 0,0,0,0,0));
    tv.push_back(mk(0,1,0,32'h9,0,0,0,0, 9,9,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,1, 9,0,0,0,0));

    for (int i = 0; i < tv.size(); i++) step_a(i);

    // No-bypass write: old value first, new after the edge
    step_b("b_nobyp0", 0,1,2,64'h048FC24A_DEADBEEF,0,0,2,2);
    step_b("b_nobyp1", 0,0,0,0,0,0,2,0);
    // Hardwired zero register ignores write and reservation
    step_b("b_zero0", 0,1,0,{64{1'b1}},1,0,0,0);
    step_b("b_zero1", 0,0,0,0,0,0,0,0);
    // Reserve/complete collision on the same register
    step_b("b_res0", 0,0,0,0,1,1,1,0);
    step_b("b_res1", 0,1,1,64'h1,1,1,1,1);
    step_b("b_res2", 0,1,1,64'h2,0,0,1,1);
    step_b("b_res3", 0,0,0,0,0,0,1,1);
    // Reserve every register, then again, then reset
    for (int i = 0; i < 16; i++)
      step_b("b_all", 0,0,0,0,1,4'(i),4'(i),0);
    step_b("b_again", 0,0,0,0,1,4'd7,4'd7,4'd15);
    step_b("b_rst", 1,0,0,0,0,0,4'd7,4'd15);
    step_b("b_after", 0,0,0,0,0,0,4'd7,4'd15);
    // Random mix
    for (int i = 0; i < 400; i++)
      step_b("b_rand", ($urandom_range(0, 39) == 0),
             1'($urandom), 4'($urandom_range(0, 15)),
             {$urandom, $urandom}, 1'($urandom),
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
